p_if: RTL and testbench

P_IF -- requirements
Module: p_if

---
 rtl/p_if.sv | 149 ++++++++++++++
 tb/tb_p_if.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/p_if.sv
// Byte-serial instruction fetch: assembles 32-bit little-endian words from an
// 8-bit memory port. Define IF_ICACHE_EN to add a direct-mapped word cache.
module p_if #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          ICACHE_LINES = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        stall_in,
  input  logic        jump_in,
  input  logic [31:0] jump_addr_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_valid_in,
  input  logic [7:0]  mem_data_in,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc_out
);

  typedef enum logic {S_FETCH, S_HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc;
  logic [1:0]  r_k;
  logic [31:0] r_word;
  logic        r_idle;
  logic        r_vld;
  logic [31:0] r_inst;
  logic [31:0] r_ipc;

  logic        w_req, w_acc, w_done, w_free, w_hit, w_fill, w_pres;
  logic [31:0] w_full, w_pword, w_cword;

  assign w_free = !r_vld || !stall_in;
  // A cache hit at k=0 replaces the whole four-byte memory sequence.
  assign w_req  = (r_state == S_FETCH) && !r_idle && !w_hit;
  assign w_acc  = mem_req_out && mem_valid_in;
  assign w_done = w_acc && (r_k == 2'd3);
  assign w_full = {mem_data_in, r_word[23:0]};
  assign w_fill = rst_in && !jump_in && w_done;

  assign mem_req_out    = rst_in && w_req;
  assign mem_addr_out   = rst_in ? (r_pc + {30'b0, r_k}) : 32'h0;
  assign inst_valid_out = r_vld;
  assign inst_out       = r_inst;
  assign inst_pc_out    = r_ipc;

`ifdef IF_ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ICACHE_LINES-1:0] r_cv;
  logic [TAG_W-1:0]        r_ctag [ICACHE_LINES];
  logic [31:0]             r_cdat [ICACHE_LINES];
  logic [IDX_W-1:0]        w_idx;

  assign w_idx   = r_pc[IDX_W+1:2];
  assign w_hit   = (r_state == S_FETCH) && !r_idle && (r_k == 2'd0) &&
                   r_cv[w_idx] && (r_ctag[w_idx] == r_pc[31:IDX_W+2]);
  assign w_cword = r_cdat[w_idx];

  always_ff @(posedge clk_in) begin
    if (!rst_in)     r_cv <= '0;
    else if (w_fill) r_cv[w_idx] <= 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (w_fill) begin
      r_ctag[w_idx] <= r_pc[31:IDX_W+2];
      r_cdat[w_idx] <= w_full;
    end
  end
`else
  assign w_hit   = 1'b0;
  assign w_cword = 32'h0;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_in) r_state <= S_FETCH;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pres      = 1'b0;
    w_pword     = r_word;
    if (jump_in) begin
      w_state_nxt = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_done) begin
            if (w_free) begin
              w_pres  = 1'b1;
              w_pword = w_full;
            end else begin
              w_state_nxt = S_HOLD;
            end
          end else if (w_hit && w_free) begin
            w_pres  = 1'b1;
            w_pword = w_cword;
          end
        end
        S_HOLD: begin
          if (w_free) begin
            w_pres      = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
        default: w_state_nxt = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_pc   <= RESET_PC;
      r_k    <= 2'd0;
      r_word <= 32'h0;
      r_idle <= 1'b0;
      r_vld  <= 1'b0;
      r_inst <= 32'h0;
      r_ipc  <= 32'h0;
    end else begin
      // The cycle after a redirect issues no request.
      r_idle <= jump_in;
      if (jump_in) begin
        r_pc  <= jump_addr_in;
        r_k   <= 2'd0;
        r_vld <= 1'b0;
      end else begin
        if (w_acc) begin
          r_word[{r_k, 3'b000} +: 8] <= mem_data_in;
          r_k <= r_k + 2'd1;
        end
        if (w_pres) begin
          r_vld  <= 1'b1;
          r_inst <= w_pword;
          r_ipc  <= r_pc;
          r_pc   <= r_pc + 32'd4;
        end else if (w_free) begin
          r_vld <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_p_if.sv
// Directed bench for p_if: byte-memory responder with programmable wait
// states, a stream-level checker of presented instructions, and literal checks.
module tb_p_if;

  logic        clk_in, rst_in, stall_in, jump_in;
  logic [31:0] jump_addr_in;
  logic        mem_req_out, mem_valid_in;
  logic [31:0] mem_addr_out;
  logic [7:0]  mem_data_in;
  logic        inst_valid_out;
  logic [31:0] inst_out, inst_pc_out;

  int checks = 0;
  int errors = 0;
  int waits  = 0;

  p_if #(.RESET_PC(32'h0), .ICACHE_LINES(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .stall_in(stall_in), .jump_in(jump_in),
    .jump_addr_in(jump_addr_in), .mem_req_out(mem_req_out),
    .mem_addr_out(mem_addr_out), .mem_valid_in(mem_valid_in),
    .mem_data_in(mem_data_in), .inst_valid_out(inst_valid_out),
    .inst_out(inst_out), .inst_pc_out(inst_pc_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h93;
      32'd1:   return 8'h00;
      32'd2:   return 8'h50;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] mword(input logic [31:0] a);
    return {mbyte(a + 32'd3), mbyte(a + 32'd2), mbyte(a + 32'd1), mbyte(a)};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  // Memory: a byte becomes valid after `waits` cycles of a steady request.
  int          wcnt = 0;
  logic        m_preq = 1'b0, m_pacc = 1'b0;
  logic [31:0] m_paddr = 32'h0;
  always @(negedge clk_in) begin
    if (mem_req_out && m_preq && !m_pacc && mem_addr_out == m_paddr) wcnt++;
    else wcnt = 0;
    mem_valid_in = mem_req_out && (wcnt >= waits);
    mem_data_in  = mem_valid_in ? mbyte(mem_addr_out) : 8'hEE;
    m_preq  = mem_req_out;
    m_paddr = mem_addr_out;
    m_pacc  = mem_valid_in;
  end

  // Stream model: every presented word is the memory word at the next program
  // address; a stalled presentation must not move.
  logic        p_rst, p_stall, p_jump, prv_vld = 1'b0;
  logic [31:0] p_jaddr, prv_inst, prv_pc, exp_pc = 32'h0;
  always begin
    @(posedge clk_in);
    p_rst = rst_in; p_stall = stall_in; p_jump = jump_in; p_jaddr = jump_addr_in;
    @(negedge clk_in);
    if (!p_rst) begin
      chk("m_rst_vld", {31'b0, inst_valid_out}, 32'd0);
      chk("m_rst_inst", inst_out, 32'h0);
      chk("m_rst_pc", inst_pc_out, 32'h0);
      if (!rst_in) chk("m_rst_req", {31'b0, mem_req_out}, 32'd0);
      exp_pc = 32'h0;
    end else if (p_jump) begin
      chk("m_jmp_vld", {31'b0, inst_valid_out}, 32'd0);
      chk("m_jmp_req", {31'b0, mem_req_out}, 32'd0);
      exp_pc = p_jaddr;
    end else if (inst_valid_out) begin
      if (prv_vld && p_stall) begin
        chk("m_hold_inst", inst_out, prv_inst);
        chk("m_hold_pc", inst_pc_out, prv_pc);
      end else begin
        chk("m_pc", inst_pc_out, exp_pc);
        chk("m_inst", inst_out, mword(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
    end
    prv_vld = inst_valid_out; prv_inst = inst_out; prv_pc = inst_pc_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int   lat;
    logic found;
    logic [31:0] spc, sinst;
    rst_in = 1'b0; stall_in = 1'b0; jump_in = 1'b0; jump_addr_in = 32'h0;
    mem_valid_in = 1'b0; mem_data_in = 8'h0;

    // Reset state and zero-wait first fetch.
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_vld", {31'b0, inst_valid_out}, 32'd0);
    chk("rst_addr", mem_addr_out, 32'h0);
    @(posedge clk_in); #1 rst_in = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_in);
      if (c <= 4) begin
        chk("z_req", {31'b0, mem_req_out}, 32'd1);
        chk("z_addr", mem_addr_out, c - 1);
      end else begin
        chk("z_vld", {31'b0, inst_valid_out}, 32'd1);
        chk("z_inst", inst_out, 32'h00500093);
        chk("z_pc", inst_pc_out, 32'h0);
      end
    end

    // Two wait states per byte.
    @(posedge clk_in); #1 rst_in = 1'b0; waits = 2;
    @(posedge clk_in); #1 rst_in = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_in);
      if (inst_valid_out) begin lat = i; break; end
    end
    chk("w2_latency", lat, 13);
    waits = 0;

    // Stall on the next presented word; following word parks until release.
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (inst_valid_out) begin found = 1'b1; break; end
    end
    chk("st_found", {31'b0, found}, 32'd1);
    spc = inst_pc_out; sinst = inst_out;
    chk("st_pc", spc, 32'h4);
    stall_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      chk("st_frz_pc", inst_pc_out, spc);
      chk("st_frz_inst", inst_out, sinst);
      chk("st_frz_vld", {31'b0, inst_valid_out}, 32'd1);
    end
    chk("st_hold_noreq", {31'b0, mem_req_out}, 32'd0);
    stall_in = 1'b0;
    @(negedge clk_in);
    chk("st_rel_vld", {31'b0, inst_valid_out}, 32'd1);
    chk("st_rel_pc", inst_pc_out, 32'h8);
    chk("st_rel_inst", inst_out, 32'h51505352);

    // Redirect while k=2.
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (mem_req_out && mem_addr_out[1:0] == 2'd2) begin found = 1'b1; break; end
    end
    chk("j_found", {31'b0, found}, 32'd1);
    jump_in = 1'b1; jump_addr_in = 32'h100;
    @(negedge clk_in);
    jump_in = 1'b0;
    chk("j_idle_vld", {31'b0, inst_valid_out}, 32'd0);
    chk("j_idle_req", {31'b0, mem_req_out}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      chk("j_req", {31'b0, mem_req_out}, 32'd1);
      chk("j_addr", mem_addr_out, 32'h100 + i);
    end
    @(negedge clk_in);
    chk("j_pc", inst_pc_out, 32'h100);

    // Address wrap through 0xFFFFFFFC.
    jump_in = 1'b1; jump_addr_in = 32'hFFFF_FFFC;
    @(negedge clk_in);
    jump_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      if (inst_valid_out && inst_pc_out == 32'h0) begin found = 1'b1; break; end
    end
    chk("wrap_found", {31'b0, found}, 32'd1);
    chk("wrap_inst", inst_out, 32'h00500093);

    // Reset while k=1.
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (mem_req_out && mem_addr_out[1:0] == 2'd1) begin found = 1'b1; break; end
    end
    chk("r1_found", {31'b0, found}, 32'd1);
    #2 rst_in = 1'b0;
    @(negedge clk_in);
    chk("r1_vld", {31'b0, inst_valid_out}, 32'd0);
    chk("r1_inst", inst_out, 32'h0);
    chk("r1_pc", inst_pc_out, 32'h0);
    chk("r1_req", {31'b0, mem_req_out}, 32'd0);
    chk("r1_addr", mem_addr_out, 32'h0);
    @(posedge clk_in); #1 rst_in = 1'b1;
    @(negedge clk_in);
    chk("r1_restart_req", {31'b0, mem_req_out}, 32'd1);
    chk("r1_restart_addr", mem_addr_out, 32'h0);
    repeat (12) @(negedge clk_in);

`ifdef IF_ICACHE_EN
    // Loop 0x40..0x4C: second pass runs from the cache.
    jump_in = 1'b1; jump_addr_in = 32'h40;
    @(negedge clk_in);
    jump_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (inst_valid_out && inst_pc_out == 32'h4C) begin found = 1'b1; break; end
    end
    chk("c_first_pass", {31'b0, found}, 32'd1);
    jump_in = 1'b1;
    @(negedge clk_in);
    jump_in = 1'b0;
    chk("c_idle_req", {31'b0, mem_req_out}, 32'd0);
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk_in);
      if (i <= 5) chk("c_noreq", {31'b0, mem_req_out}, 32'd0);
      if (i >= 3) begin
        chk("c_vld", {31'b0, inst_valid_out}, 32'd1);
        chk("c_pc", inst_pc_out, 32'h40 + 32'(4 * (i - 3)));
      end
    end
`endif

    repeat (4) @(negedge clk_in);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
